// File: rtl/zint_pkg.sv
// Shared definitions for the ZX-bus INT pulse generator.
package zint_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } zint_state_t;

    localparam int PEND_W5300 = 0;
    localparam int PEND_SL811 = 1;

endpackage

// File: rtl/zint_gen_sync2.sv
// Two-flop synchroniser with a configurable reset level.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic fclk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/zint_gen.sv
// Synchronises W5300/SL811 interrupts, latches them as pending bits and emits
// bounded-width, rate-limited INT pulses.  States: IDLE | wait for pending,
// PULSE | INT driven low, HOLDOFF | enforced gap before the next pulse.
module zint_gen
    import zint_pkg::*;
#(
    parameter int PULSE_CYCLES   = 32,
    parameter int HOLDOFF_CYCLES = 256
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       w5300_int_n,
    input  logic       sl811_intrq,
    input  logic       ena_w5300_int,
    input  logic       ena_sl811_int,
    input  logic       ena_zxbus_int,
    input  logic       stat_rd_stb,
    output logic [1:0] pending,
    output logic       zint_oe,
    output logic       busy
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES <= 1) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    logic        w5300_int_n_s;
    logic        sl811_intrq_s;
    logic [1:0]  req;
    logic [1:0]  ena_src;

    zint_state_t      state;
    logic [CNT_W-1:0] cnt;

    sync2 #(.RST_VAL(1'b1)) u_sync_w5300 (
        .fclk  (fclk),
        .rst_n (rst_n),
        .d     (w5300_int_n),
        .q     (w5300_int_n_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_sl811 (
        .fclk  (fclk),
        .rst_n (rst_n),
        .d     (sl811_intrq),
        .q     (sl811_intrq_s)
    );

    assign req[PEND_W5300]     = ~w5300_int_n_s & ena_w5300_int;
    assign req[PEND_SL811]     = sl811_intrq_s & ena_sl811_int;
    assign ena_src[PEND_W5300] = ena_w5300_int;
    assign ena_src[PEND_SL811] = ena_sl811_int;

    // Set beats clear, so a source still asserted survives a status read.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req[i])
                    pending[i] <= 1'b1;
                else if (stat_rd_stb || !ena_src[i])
                    pending[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            zint_oe <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((|pending) && ena_zxbus_int) begin
                        state   <= PULSE;
                        cnt     <= PULSE_LOAD;
                        zint_oe <= 1'b1;
                    end
                end
                PULSE: begin
                    if (!ena_zxbus_int || cnt == '0) begin
                        state   <= HOLDOFF;
                        cnt     <= HOLDOFF_LOAD;
                        zint_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    zint_oe <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == PULSE) || (state == HOLDOFF);

endmodule

// File: doc/zint_gen.md
# zint_gen

Clocked interrupt pulse generator for the ZX-bus INT line.
- Synchronises the W5300 and SL811 interrupt requests into the `fclk` domain and latches them as per-source pending bits.
- Emits a bounded-width, rate-limited INT pulse towards the ZX bus.
- Sits downstream of the `ports` enables and upstream of the open-drain `zint_n` driver, which becomes `zint_n = zint_oe ? 1'b0 : 1'bZ`.
- Replaces the purely combinational level drive of INT.

## Interface
Parameters:
- `PULSE_CYCLES`, default 32: INT assertion width in `fclk` cycles; must be ≥1.
- `HOLDOFF_CYCLES`, default 256: minimum deasserted gap after a pulse, in `fclk` cycles; must be ≥1.

Ports:
- `fclk`, in, 1: the single clock. All state changes on its rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `w5300_int_n`, in, 1: W5300 interrupt, active-low, asynchronous to `fclk`.
- `sl811_intrq`, in, 1: SL811 interrupt, active-high, asynchronous to `fclk`.
- `ena_w5300_int`, in, 1: source enable from `ports`; quasi-static.
- `ena_sl811_int`, in, 1: source enable from `ports`; quasi-static.
- `ena_zxbus_int`, in, 1: master enable for driving INT.
- `stat_rd_stb`, in, 1: one-cycle pulse in the `fclk` domain, issued by upstream when the status port is read. Clears pending bits.
- `pending`, out, 2: latched pending bits `{sl811, w5300}`.
- `zint_oe`, out, 1: 1 means pull ZX-bus INT low.
- `busy`, out, 1: 1 while in PULSE or HOLDOFF.

## Operation
Synchronisation and requests:
- Each interrupt input passes through a two-flop synchroniser; synchroniser reset value is "not requesting".
- Requests: `w_req = ~sync(w5300_int_n) & ena_w5300_int`; `s_req = sync(sl811_intrq) & ena_sl811_int`.

Pending bits (level-sensitive), evaluated each cycle:
- Req high: bit is set.
- Else, `stat_rd_stb` high: bit is cleared.
- Else, source enable low: bit is cleared.
- Otherwise: bit holds.
- Set always wins over clear. A source still asserted therefore stays pending after a status read.

FSM, states IDLE, PULSE, HOLDOFF; down-counter `cnt` of width `$clog2(max(PULSE_CYCLES, HOLDOFF_CYCLES))`, minimum 1:
- IDLE: if `|pending & ena_zxbus_int`, load `cnt = PULSE_CYCLES-1` and go to PULSE.
- PULSE: `zint_oe = 1`. When `cnt == 0`, load `cnt = HOLDOFF_CYCLES-1` and go to HOLDOFF; otherwise decrement.
- PULSE with `ena_zxbus_int` low: `zint_oe` drops next edge and the FSM goes to HOLDOFF with a full holdoff load.
- HOLDOFF: `zint_oe = 0`. When `cnt == 0`, go to IDLE; otherwise decrement.
- HOLDOFF is never skipped.
- Pending clears during PULSE do not shorten the pulse.

Outputs:
- `zint_oe` is a registered output: 1 exactly when state is PULSE. No combinational path from any input.
- `busy` is 1 when state is PULSE or HOLDOFF.
- Reset values: state IDLE, `cnt` 0, `pending` 00, `zint_oe` 0, `busy` 0. Synchronisers reset to the idle level.

## Timing
Latency:
- E0 is the `fclk` edge that first samples an asserted input.
- Synchroniser output is high after E1, `pending` after E2, `zint_oe` after E3.
- Input-to-INT latency is therefore 4 edges (3 or 4 cycles, depending on input phase).

Pulse and gap:
- `zint_oe` is high for exactly `PULSE_CYCLES` cycles.
- If still pending, the gap before the next pulse is `HOLDOFF_CYCLES + 1` cycles, including one IDLE cycle.

Status read:
- `pending` is visible to the status read in the same cycle as `stat_rd_stb`.
- The clear takes effect after that edge.

Simultaneous events:
- Set and clear in the same cycle: set wins.
- Both sources in the same cycle produce one pulse.

Reset mid-pulse:
- `zint_oe` goes low asynchronously on `rst_n` fall.
- The FSM restarts in IDLE with no pending bits.

## Structure
- Shared package `zint_pkg`: FSM state encoding constants (IDLE=2'd0, PULSE=2'd1, HOLDOFF=2'd2) and the pending-bit index constants `PEND_W5300 = 0`, `PEND_SL811 = 1`.
- Sub-module `sync2`: a two-flop synchroniser with a reset-value parameter, instantiated once per interrupt input.
- Counter and FSM live in `zint_gen`.

## Test plan
Defaults `PULSE_CYCLES = 32`, `HOLDOFF_CYCLES = 256`, all enables 1.
1. `w5300_int_n` falls for 1 µs → `pending = 01`; `zint_oe` high 4 edges after E0 for exactly 32 cycles, then low; `busy` high for 288 cycles.
2. `sl811_intrq` held high, `stat_rd_stb` pulsed every 100 cycles → `pending[1]` stays 1; pulses repeat with a 257-cycle gap; no pulse longer than 32 cycles.
3. Source deasserted, then `stat_rd_stb` → `pending = 00` next edge; no further pulse after HOLDOFF.
4. `ena_zxbus_int` = 0 with a pending source → `zint_oe` stays 0 and `pending` = 01. Setting enable to 1 → pulse starts 1 cycle later. Dropping it at PULSE cycle 10 → `zint_oe` low next edge, HOLDOFF for 256 cycles.
5. `ena_w5300_int` = 0 with `w5300_int_n` low → `pending[0]` = 0 and no pulse. A previously set `pending[0]` clears one edge after the enable drops.
6. `rst_n` asserted at PULSE cycle 5 → `zint_oe`, `busy` and `pending` go to 0 immediately. After release with sources idle → no pulse for 1000 cycles.
